k_and_s_datapath: RTL and testbench

Datapath of the K&S multicycle processor, the counterpart of `control_unit`. It holds PC, IR, the 4×16-bit register file, the ALU and the flag register, and it decodes IR into `decoded_instruction` plus registered ALU flags for the control unit. It executes the per-cycle enables and selects that `control_unit` drives. It also drives the 32-word RAM's address and write-data lines and accepts RAM read data.

---
 rtl/k_and_s_datapath.sv | 145 ++++++++++++++
 tb/tb_k_and_s_datapath.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k_and_s_datapath.sv
// Datapath of the K&S multicycle processor: PC, IR, 4x16 register file, ALU and flags.
// The control unit sequences it through per-cycle enables and selects.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module k_and_s_datapath
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    flags_reg_enable,
  input  logic [1:0]              operation,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [4:0]              ram_addr,
  output logic [15:0]             data_out,
  input  logic [15:0]             data_in
);
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic [ADDR_W-1:0]        pc;
  logic [DATA_W-1:0]        ir;
  logic [DATA_W-1:0]        regs [4];
  logic [1:0]               ra_idx, rb_idx, rd_idx;
  logic signed [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [DATA_W:0]          alu_wide;
  logic                     alu_uov, alu_sov;
  logic [DATA_W-1:0]        wr_data;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a, b, r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a, b, r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  assign ram_addr = addr_sel ? pc : ir[4:0];
  assign data_out = regs[ir[6:5]];

  always_comb begin
    decoded_instruction = I_NOP;
    case (ir[15:8])
      8'hFF:   decoded_instruction = I_HALT;
      8'h01:   decoded_instruction = I_BRANCH;
      8'h02:   decoded_instruction = I_BZERO;
      8'h03:   decoded_instruction = I_BNZERO;
      8'h04:   decoded_instruction = I_BNEG;
      8'h05:   decoded_instruction = I_BNNEG;
      8'h06:   decoded_instruction = I_BOV;
      8'h07:   decoded_instruction = I_BNOV;
      8'h81:   decoded_instruction = I_LOAD;
      8'h82:   decoded_instruction = I_STORE;
      8'h91:   decoded_instruction = I_MOVE;
      8'hA1:   decoded_instruction = I_ADD;
      8'hA2:   decoded_instruction = I_SUB;
      8'hA3:   decoded_instruction = I_AND;
      8'hA4:   decoded_instruction = I_OR;
      default: decoded_instruction = I_NOP;
    endcase
  end

  // Register fields sit in different IR positions depending on the instruction class.
  always_comb begin
    ra_idx = ir[3:2];
    rb_idx = ir[1:0];
    rd_idx = ir[5:4];
    case (decoded_instruction)
      I_LOAD: rd_idx = ir[6:5];
      I_MOVE: begin
        rd_idx = ir[3:2];
        ra_idx = ir[1:0];
      end
      default: ;
    endcase
  end

  // MOVE feeds ra into both ALU inputs; the control unit issues OR so the result is ra.
  assign alu_a = regs[ra_idx];
  assign alu_b = (decoded_instruction == I_MOVE) ? regs[ra_idx] : regs[rb_idx];

  always_comb begin
    alu_wide = '0;
    alu_sov  = 1'b0;
    case (operation)
      2'b00: begin
        alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_sov  = add_ovf(alu_a, alu_b, $signed(alu_wide[DATA_W-1:0]));
      end
      2'b01: begin
        alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_sov  = sub_ovf(alu_a, alu_b, $signed(alu_wide[DATA_W-1:0]));
      end
      2'b10:   alu_wide = {1'b0, alu_a & alu_b};
      default: alu_wide = {1'b0, alu_a | alu_b};
    endcase
  end

  assign alu_res = $signed(alu_wide[DATA_W-1:0]);
  assign alu_uov = ~operation[1] & alu_wide[DATA_W];
  assign wr_data = c_sel ? alu_res : data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                <= '0;
      ir                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else begin
      if (pc_enable) pc <= branch ? ir[4:0] : pc + 5'd1;
      if (ir_enable) ir <= data_in;
      if (flags_reg_enable) begin
        zero_op           <= (alu_res == '0);
        neg_op            <= alu_res[DATA_W-1];
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      regs[rd_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_k_and_s_datapath.sv
// Bench for k_and_s_datapath: directed scenarios plus randomized control sequences
// against an instruction-level model of PC, IR, register file and flags.
module tb_k_and_s_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch = 0, pc_enable = 0, ir_enable = 0, write_reg_enable = 0;
  logic addr_sel = 1, c_sel = 0, flags_reg_enable = 0;
  logic [1:0] operation = 2'b00;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0] ram_addr;
  logic [15:0] data_out, data_in;
  logic [15:0] ram [32];

  assign data_in = ram[ram_addr];

  k_and_s_datapath dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .write_reg_enable(write_reg_enable), .addr_sel(addr_sel),
    .c_sel(c_sel), .flags_reg_enable(flags_reg_enable), .operation(operation),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference state
  logic [4:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_reg [4];
  logic        m_z, m_n, m_u, m_s;

  function automatic decoded_instruction_type decode_model(input logic [15:0] w);
    case (w[15:8])
      8'hFF: return I_HALT;
      8'h01: return I_BRANCH;
      8'h02: return I_BZERO;
      8'h03: return I_BNZERO;
      8'h04: return I_BNEG;
      8'h05: return I_BNNEG;
      8'h06: return I_BOV;
      8'h07: return I_BNOV;
      8'h81: return I_LOAD;
      8'h82: return I_STORE;
      8'h91: return I_MOVE;
      8'hA1: return I_ADD;
      8'hA2: return I_SUB;
      8'hA3: return I_AND;
      8'hA4: return I_OR;
      default: return I_NOP;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ir = '0;
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    {m_z, m_n, m_u, m_s} = 4'b0;
  endtask

  // Drive one cycle of control, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic br, pce, ire, wre, asel, csel, fle, input logic [1:0] op);
    decoded_instruction_type cls;
    logic [15:0] din, a, b, res;
    logic [1:0] ra, rb, rd;
    logic u, sv;
    int full, sa, sb, s;
    branch = br; pc_enable = pce; ir_enable = ire; write_reg_enable = wre;
    addr_sel = asel; c_sel = csel; flags_reg_enable = fle; operation = op;
    cls = decode_model(m_ir);
    din = ram[asel ? m_pc : m_ir[4:0]];
    ra = (cls == I_MOVE) ? m_ir[1:0] : m_ir[3:2];
    rb = m_ir[1:0];
    rd = (cls == I_LOAD) ? m_ir[6:5] : (cls == I_MOVE) ? m_ir[3:2] : m_ir[5:4];
    a = m_reg[ra];
    b = (cls == I_MOVE) ? m_reg[ra] : m_reg[rb];
    sa = int'($signed(a));
    sb = int'($signed(b));
    u = 1'b0; sv = 1'b0;
    case (op)
      2'd0: begin
        full = int'(a) + int'(b); res = 16'(full); u = (full > 65535);
        s = sa + sb; sv = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        res = a - b; u = (a < b);
        s = sa - sb; sv = (s > 32767) || (s < -32768);
      end
      2'd2: res = a & b;
      default: res = a | b;
    endcase
    @(posedge clk);
    if (fle) begin m_z = (res == 16'd0); m_n = res[15]; m_u = u; m_s = sv; end
    if (wre) m_reg[rd] = csel ? res : din;
    if (pce) m_pc = br ? m_ir[4:0] : m_pc + 5'd1;
    if (ire) m_ir = din;
    #1;
    branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
    c_sel = 0; flags_reg_enable = 0;
  endtask

  task automatic set_ir(input logic [15:0] w);
    ram[m_pc] = w;
    cycle(0, 0, 1, 0, 1, 0, 0, 2'd0);
  endtask

  task automatic load_reg(input logic [1:0] r, input logic [15:0] v);
    set_ir({8'h81, 1'b0, r, 5'd30});
    ram[30] = v;
    cycle(0, 0, 0, 1, 0, 0, 0, 2'd0);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
    set_ir({8'h00, 1'b0, r, 5'd0});
    v = data_out;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    model_reset();
    addr_sel = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    #1;
    n_tests++;
    if (ram_addr !== 5'd0 || data_out !== 16'd0 || decoded_instruction !== I_NOP ||
        {zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_initial: addr=%0d dout=%h dec=%s flags=%b, want 0 0 I_NOP 0000",
               ram_addr, data_out, decoded_instruction.name(),
               {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    // Put state into every register class, then reset mid-cycle.
    set_ir(16'hA11B);
    cycle(1, 1, 0, 0, 1, 0, 1, 2'd0);
    load_reg(2'd2, 16'hBEEF);
    #2 rst_n = 0;
    addr_sel = 1;
    #1;
    model_reset();
    n_tests++;
    if (ram_addr !== 5'd0 || data_out !== 16'd0 || decoded_instruction !== I_NOP ||
        {zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: addr=%0d dout=%h dec=%s flags=%b, want 0 0 I_NOP 0000",
               ram_addr, data_out, decoded_instruction.name(),
               {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    @(posedge clk);
    #3 rst_n = 1;
    read_reg(2'd2, v);
    n_tests++;
    if (v !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs: r2=%h want 0000", v);
    end
  endtask

  task automatic test_fetch();
    ram[0] = 16'hA11B;
    cycle(0, 1, 1, 0, 1, 0, 0, 2'd0);
    n_tests++;
    if (decoded_instruction !== I_ADD) begin
      n_fail++;
      $display("FAIL fetch_decode: got %s want I_ADD", decoded_instruction.name());
    end
    addr_sel = 0; #1;
    n_tests++;
    if (ram_addr !== 5'h1B) begin
      n_fail++;
      $display("FAIL fetch_ir: ir[4:0]=%h want 1b", ram_addr);
    end
    addr_sel = 1; #1;
    n_tests++;
    if (ram_addr !== 5'd1) begin
      n_fail++;
      $display("FAIL fetch_pc: pc=%0d want 1", ram_addr);
    end
  endtask

  task automatic test_add_overflow();
    logic [15:0] v;
    load_reg(2'd2, 16'h7FFF);
    load_reg(2'd3, 16'h0001);
    set_ir(16'hA11B);
    cycle(0, 0, 0, 1, 0, 1, 1, 2'd0);
    n_tests++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0101) begin
      n_fail++;
      $display("FAIL add_flags: znus=%b want 0101",
               {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    read_reg(2'd1, v);
    n_tests++;
    if (v !== 16'h8000) begin
      n_fail++;
      $display("FAIL add_result: r1=%h want 8000", v);
    end
  endtask

  task automatic test_sub();
    logic [15:0] v;
    load_reg(2'd2, 16'd5);
    load_reg(2'd3, 16'd5);
    set_ir(16'hA21B);
    cycle(0, 0, 0, 1, 0, 1, 1, 2'd1);
    n_tests++;
    if (zero_op !== 1'b1 || unsigned_overflow !== 1'b0 || neg_op !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_equal: z=%b n=%b u=%b want 1 0 0", zero_op, neg_op, unsigned_overflow);
    end
    load_reg(2'd2, 16'd0);
    load_reg(2'd3, 16'd1);
    set_ir(16'hA21B);
    cycle(0, 0, 0, 1, 0, 1, 1, 2'd1);
    n_tests++;
    if (neg_op !== 1'b1 || unsigned_overflow !== 1'b1 || zero_op !== 1'b0 || signed_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: z=%b n=%b u=%b s=%b want 0 1 1 0",
               zero_op, neg_op, unsigned_overflow, signed_overflow);
    end
    read_reg(2'd1, v);
    n_tests++;
    if (v !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sub_result: r1=%h want ffff", v);
    end
  endtask

  task automatic test_load_store();
    ram[5] = 16'h1234;
    set_ir(16'h8125);
    addr_sel = 0; #1;
    n_tests++;
    if (ram_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL load_addr: addr=%0d want 5", ram_addr);
    end
    cycle(0, 0, 0, 1, 0, 0, 0, 2'd0);
    set_ir(16'h8227);
    addr_sel = 0; #1;
    n_tests++;
    if (ram_addr !== 5'd7 || data_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL store: addr=%0d dout=%h want 7 1234", ram_addr, data_out);
    end
  endtask

  task automatic test_move();
    logic [15:0] v, src;
    src = 16'($urandom);
    load_reg(2'd1, src);
    load_reg(2'd3, ~src);
    set_ir(16'h910D);
    cycle(0, 0, 0, 1, 0, 1, 1, 2'd3);
    n_tests++;
    if (zero_op !== m_z || neg_op !== m_n) begin
      n_fail++;
      $display("FAIL move_flags: z=%b n=%b want %b %b", zero_op, neg_op, m_z, m_n);
    end
    read_reg(2'd3, v);
    n_tests++;
    if (v !== src) begin
      n_fail++;
      $display("FAIL move_result: r3=%h want %h", v, src);
    end
  endtask

  task automatic test_alu_random();
    logic [15:0] v;
    logic [1:0] op;
    for (int k = 0; k < 24; k++) begin
      op = 2'(k % 4);
      load_reg(2'd2, (k < 4) ? 16'h8000 : 16'($urandom));
      load_reg(2'd3, (k < 4) ? 16'h8000 : 16'($urandom));
      set_ir({8'hA1 + 8'(op), 8'h1B});
      cycle(0, 0, 0, 1, 0, 1, 1, op);
      read_reg(2'd1, v);
      n_tests++;
      if (v !== m_reg[1] || {zero_op, neg_op, unsigned_overflow, signed_overflow} !== {m_z, m_n, m_u, m_s}) begin
        n_fail++;
        $display("FAIL alu_random op=%0d: r1=%h zuns=%b want %h %b", op, v,
                 {zero_op, neg_op, unsigned_overflow, signed_overflow}, m_reg[1], {m_z, m_n, m_u, m_s});
      end
    end
  endtask

  task automatic test_pc();
    int guard = 0;
    while (m_pc != 5'd31 && guard < 40) begin
      cycle(0, 1, 0, 0, 1, 0, 0, 2'd0);
      guard++;
    end
    addr_sel = 1; #1;
    n_tests++;
    if (ram_addr !== 5'd31) begin
      n_fail++;
      $display("FAIL pc_reach31: pc=%0d want 31", ram_addr);
    end
    cycle(0, 1, 0, 0, 1, 0, 0, 2'd0);
    n_tests++;
    if (ram_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%0d want 0", ram_addr);
    end
    set_ir(16'h0113);
    cycle(1, 1, 0, 0, 1, 0, 0, 2'd0);
    n_tests++;
    if (ram_addr !== 5'd19 || decoded_instruction !== I_BRANCH) begin
      n_fail++;
      $display("FAIL pc_branch: pc=%0d dec=%s want 19 I_BRANCH", ram_addr, decoded_instruction.name());
    end
    cycle(1, 0, 0, 0, 1, 0, 0, 2'd0);
    cycle(0, 0, 0, 0, 1, 0, 0, 2'd0);
    addr_sel = 1; #1;
    n_tests++;
    if (ram_addr !== 5'd19) begin
      n_fail++;
      $display("FAIL pc_hold: pc=%0d want 19", ram_addr);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [17] = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h5C};
    decoded_instruction_type cls;
    logic alu_ok, wre, csel, fle;
    for (int i = 0; i < 32; i++) ram[i] = {ops[$urandom_range(0, 16)], 8'($urandom)};
    for (int n = 0; n < 300; n++) begin
      cls = decode_model(m_ir);
      alu_ok = (cls inside {I_ADD, I_SUB, I_AND, I_OR, I_MOVE});
      wre  = 1'($urandom);
      csel = 1'($urandom) & alu_ok;
      fle  = 1'($urandom) & alu_ok;
      cycle(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), wre,
            1'($urandom), csel, fle, 2'($urandom));
      addr_sel = 0; #1;
      n_tests++;
      if (ram_addr !== m_ir[4:0] || decoded_instruction !== decode_model(m_ir) ||
          data_out !== m_reg[m_ir[6:5]] ||
          {zero_op, neg_op, unsigned_overflow, signed_overflow} !== {m_z, m_n, m_u, m_s}) begin
        n_fail++;
        $display("FAIL random[%0d]: ir_addr=%h dec=%s dout=%h zuns=%b want %h %s %h %b", n,
                 ram_addr, decoded_instruction.name(), data_out,
                 {zero_op, neg_op, unsigned_overflow, signed_overflow},
                 m_ir[4:0], decode_model(m_ir).name(), m_reg[m_ir[6:5]], {m_z, m_n, m_u, m_s});
      end
      addr_sel = 1; #1;
      n_tests++;
      if (ram_addr !== m_pc) begin
        n_fail++;
        $display("FAIL random_pc[%0d]: pc=%0d want %0d", n, ram_addr, m_pc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    test_reset();
    test_fetch();
    test_add_overflow();
    test_sub();
    test_load_store();
    test_move();
    test_alu_random();
    test_pc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
